// File: rtl/sprite_line_fetch_if.sv
// sprite_line_fetch_if: sprite memory read port; mem_data is valid in the mem_ack cycle.
interface sprite_line_fetch_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_WIDTH = 24
);
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_data;
    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: fetches one sprite row per hblank into a line buffer and streams it as pixel/pix_en.
// Define SPRITE_MIRROR_EN to add the spr_flip horizontal-mirror input.
module sprite_line_fetch #(
    parameter int DATA_WIDTH    = 24,
    parameter int SPR_W         = 32,
    parameter int SPR_H         = 32,
    parameter int ADDR_W        = 16,
    parameter int SPR_BASE      = 0,
    parameter int H_ACTIVE      = 640,
    parameter int H_FETCH_START = 640,
    parameter int V_TOTAL       = 525,
    parameter int V_LATCH       = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_tick,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  bright,
    input  logic [9:0]            spr_x,
    input  logic [9:0]            spr_y,
    input  logic                  spr_show,
`ifdef SPRITE_MIRROR_EN
    input  logic                  spr_flip,
`endif
    sprite_line_fetch_if.master   mem,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  pix_en,
    output logic                  fetch_overrun
);
    localparam int IW = $clog2(SPR_W);
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_d;

    logic [DATA_WIDTH-1:0] line_buf [SPR_W];
    logic [IW-1:0]         idx, rd_idx;
    logic [RW-1:0]         row;
    logic                  row_valid_next, row_valid_cur, row_valid_cur_d;
    logic [9:0]            sx, sy;
    logic                  show;
    logic [10:0]           nl, rel, col;
    logic                  line_start, fetch_tick, hit, last_ack, pix_hit;
`ifdef SPRITE_MIRROR_EN
    logic                  flip;
`endif

    always_comb begin
        line_start = pix_tick && hcount == 10'd0;
        fetch_tick = pix_tick && hcount == 10'(H_FETCH_START);
        nl = (vcount == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, vcount} + 11'd1;
        rel = nl - {1'b0, sy};
        hit = show && nl >= {1'b0, sy} && rel < 11'(SPR_H);
        last_ack = state == FETCH && mem.mem_ack && idx == IW'(SPR_W - 1);
        // a final ack coinciding with line start still makes the new row visible
        row_valid_cur_d = !line_start ? row_valid_cur : last_ack ? 1'b1 : state == FETCH ? 1'b0 : row_valid_next;
        col = {1'b0, hcount} - {1'b0, sx};
`ifdef SPRITE_MIRROR_EN
        rd_idx = flip ? ~col[IW-1:0] : col[IW-1:0];
`else
        rd_idx = col[IW-1:0];
`endif
        pix_hit = bright && row_valid_cur_d && {1'b0, hcount} < 11'(H_ACTIVE) && hcount >= sx && col < 11'(SPR_W);
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = (fetch_tick && hit) ? FETCH : IDLE;
            FETCH:   state_d = last_ack ? IDLE : line_start ? DRAIN : FETCH;
            DRAIN:   state_d = mem.mem_ack ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    assign mem.mem_req  = state != IDLE;
    assign mem.mem_addr = mem.mem_req ? ADDR_W'(SPR_BASE) + ADDR_W'({row, idx}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            row            <= '0;
            row_valid_next <= 1'b0;
            row_valid_cur  <= 1'b0;
            fetch_overrun  <= 1'b0;
            sx             <= '0;
            sy             <= '0;
            show           <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            flip           <= 1'b0;
`endif
            pixel          <= '0;
            pix_en         <= 1'b0;
        end else begin
            row_valid_cur <= row_valid_cur_d;
            if (state == IDLE && fetch_tick) begin
                row_valid_next <= 1'b0;
                row            <= rel[RW-1:0];
                idx            <= '0;
            end
            if (state == FETCH && mem.mem_ack) idx <= idx + 1'b1;
            if (last_ack) row_valid_next <= 1'b1;
            if (line_start && state == FETCH && !last_ack) fetch_overrun <= 1'b1;
            if (line_start && vcount == 10'(V_LATCH)) begin
                sx   <= spr_x;
                sy   <= spr_y;
                show <= spr_show;
`ifdef SPRITE_MIRROR_EN
                flip <= spr_flip;
`endif
            end
            if (pix_tick) begin
                pix_en <= pix_hit;
                pixel  <= pix_hit ? line_buf[rd_idx] : '0;
            end
        end
    end

    // drained words are discarded so a late ack cannot corrupt the buffer
    always_ff @(posedge clk)
        if (state == FETCH && mem.mem_ack) line_buf[idx] <= mem.mem_data;
endmodule

// File: doc/sprite_line_fetch.md
Name: sprite_line_fetch

Overview:
- Producer side of the pixel/pix_en interface consumed by bitgen.
- Fetches one row of a single sprite from sprite memory into an internal line buffer during horizontal blank, via a req/ack read handshake.
- During the active region, outputs pixel/pix_en registered to the current hcount/vcount.
- Sits between the VGA timing generator and bitgen; the top level delays hcount/vcount/bright by one pix_tick into bitgen.

Parameters:
- DATA_WIDTH, 24: pixel word width.
- SPR_W, 32: sprite width in pixels; must be a power of two.
- SPR_H, 32: sprite height in lines.
- ADDR_W, 16: sprite memory address width.
- SPR_BASE, 0: memory word address of sprite row 0, pixel 0.
- H_ACTIVE, 640: number of visible pixels per line.
- H_FETCH_START, 640: hcount at which the next-line fetch starts; must be >= H_ACTIVE.
- V_TOTAL, 525: lines per frame.
- V_LATCH, 480: line on which the sprite position is shadowed.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- pix_tick, in, 1: one-clk pixel enable; hcount/vcount advance on cycles where it is high.
- hcount, in, 10: current pixel column.
- vcount, in, 10: current line.
- bright, in, 1: high in the visible region.
- spr_x, in, 10: sprite left edge, live value.
- spr_y, in, 10: sprite top edge, live value.
- spr_show, in, 1: sprite enable, live value.
- mem_req, out, 1: read request.
- mem_addr, out, ADDR_W: read address.
- mem_ack, in, 1: read complete; mem_data is valid in the same cycle.
- mem_data, in, DATA_WIDTH: read data.
- pixel, out, DATA_WIDTH: sprite pixel to bitgen.
- pix_en, out, 1: pixel valid to bitgen.
- fetch_overrun, out, 1: sticky flag, set when a fetch is aborted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, row_valid_next=0, row_valid_cur=0, shadow registers (sx, sy, show) = 0. Line buffer contents are don't-care.
- Shadow latch: on a pix_tick cycle with hcount==0 and vcount==V_LATCH, load sx<=spr_x, sy<=spr_y, show<=spr_show. Position changes mid-frame never tear.
- Next line: nl = (vcount==V_TOTAL-1) ? 0 : vcount+1.
- Row hit: show && nl>=sy && (nl-sy)<SPR_H. All compares use 11-bit arithmetic, with no wrap past 1023.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH: on a pix_tick cycle with hcount==H_FETCH_START and row hit. Set row=nl-sy, i=0, row_valid_next=0.
  - IDLE, same trigger without a row hit: clear row_valid_next and stay in IDLE.
  - FETCH: mem_req=1, mem_addr=SPR_BASE+row*SPR_W+i. Address is held stable while req is high.
    - On mem_ack, write buf[i]<=mem_data and increment i.
    - If i==SPR_W-1 at ack: set row_valid_next=1, drop req the next cycle, go to IDLE.
    - req stays asserted across consecutive acks, one word per acked cycle.
  - Fetch runs at clk rate and ignores pix_tick.
- Line start: on a pix_tick cycle with hcount==0:
  - row_valid_cur <= row_valid_next.
  - If the FSM is in FETCH: row_valid_cur<=0, fetch_overrun<=1, go to DRAIN.
  - DRAIN keeps req high until the outstanding ack, discards that data, then goes to IDLE.
- Handshake rule: mem_req never deasserts without a mem_ack.
- Pixel output, updated only on pix_tick cycles (1-pixel latency):
  - When bright && row_valid_cur && hcount<H_ACTIVE && hcount>=sx && (hcount-sx)<SPR_W: pixel<=buf[hcount-sx], pix_en<=1.
  - Otherwise pixel<=0, pix_en<=0.
  - Outputs hold value between ticks.
  - A buffer word of 0 is passed through with pix_en=1; bitgen treats it as transparent.
- Sprite partly off the right edge: columns >= H_ACTIVE are suppressed.
- Simultaneous events:
  - Line start and final ack in the same cycle: the ack wins. The fetch completes and row_valid_cur takes the new value 1.
  - Shadow latch during a fetch: the in-flight row uses the values latched at FETCH entry.
- Reset mid-fetch: mem_req drops immediately on reset; the memory side must tolerate this.
- fetch_overrun clears only on reset.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- Defined: adds input spr_flip (1 bit), shadowed with the position. When the shadowed flip bit is 1, the read index is SPR_W-1-(hcount-sx), giving a horizontal mirror; the fetch order is unchanged.
- Undefined: the port is absent and the index is always hcount-sx.

Test Plan:
- Mem acks every cycle, spr_x=100, spr_y=50, spr_show=1 latched at line 480:
  - Line 49 fetch issues addresses 0..31 (row 0).
  - On line 50, pix_en=1 exactly for hcount 100..131.
  - pixel equals word (hcount-100) of row 0.
- Ack delayed 3 cycles per word: mem_addr stays stable while req is high. Row 5 fetch for line 55 covers addresses 160..191.
- Ack withheld past hcount==0:
  - fetch_overrun=1 and pix_en=0 for the whole line.
  - req stays high until the next ack, then drops; the following line fetches normally.
- spr_x=620: pix_en only for hcount 620..639. spr_y=500 with vcount 524: nl=0 is not a hit.
- spr_x changed at line 200: output is unchanged until after line 480; the new position appears from the next frame.
- With SPRITE_MIRROR_EN and spr_flip=1, spr_x=100: hcount 100 outputs buf[31] and hcount 131 outputs buf[0].
